psum_maxpool_buffer: RTL and testbench



---
 rtl/cnn_pkg.sv | 22 ++
 rtl/sync_fwft_fifo.sv | 75 +++++++
 rtl/psum_maxpool_buffer.sv | 143 ++++++++++++++
 tb/tb_psum_maxpool_buffer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath: Psum width, default map size
// and the unsigned max helper used by the pooling stage.
package cnn_pkg;

   localparam int PSUM_W    = 8;
   localparam int IMG_W_DEF = 26;
   localparam int IMG_H_DEF = 26;

   typedef logic [PSUM_W-1:0] psum_t;

   // Unsigned maximum; on a tie either operand is correct, a is returned.
   function automatic psum_t psum_max(input psum_t a, input psum_t b);
      psum_t r;
      if (a >= b) begin
         r = a;
      end else begin
         r = b;
      end
      return r;
   endfunction

endpackage

// File: rtl/sync_fwft_fifo.sv
// Small synchronous first-word-fall-through FIFO. The head entry is always
// visible on head_data; pop advances it. clear flushes the pointers.
module sync_fwft_fifo #(
   parameter int W     = 9,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          push,
   input  logic [W-1:0]  push_data,
   input  logic          pop,
   output logic [W-1:0]  head_data,
   output logic          full,
   output logic          empty,
   output logic [CW-1:0] count
);

   logic [W-1:0]  mem_r [0:DEPTH-1];
   logic [AW-1:0] wr_ptr_r;
   logic [AW-1:0] rd_ptr_r;
   logic [CW-1:0] count_r;
   logic          do_push_s;
   logic          do_pop_s;

   // Qualify requests so an overflow or underflow can never corrupt state.
   always_comb begin
      do_push_s = push & (count_r != CW'(DEPTH));
      do_pop_s  = pop & (count_r != {CW{1'b0}});
   end

   // Storage; reset to zero so the head reads zero straight out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (do_push_s) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

   // Pointers wrap naturally at the power-of-two depth; count tracks occupancy.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else if (clear) begin
         wr_ptr_r <= {AW{1'b0}};
         rd_ptr_r <= {AW{1'b0}};
         count_r  <= {CW{1'b0}};
      end else begin
         if (do_push_s) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (do_pop_s) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({do_push_s, do_pop_s})
            2'b10:   count_r <= count_r + CW'(1);
            2'b01:   count_r <= count_r - CW'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   assign head_data = mem_r[rd_ptr_r];
   assign full      = (count_r == CW'(DEPTH));
   assign empty     = (count_r == {CW{1'b0}});
   assign count     = count_r;

endmodule

// File: rtl/psum_maxpool_buffer.sv
// 2x2 stride-2 max pooling over a raster-ordered Psum map. Horizontal pairs
// are reduced through a hold register, even-row pair maxima are parked in a
// half-width line buffer, and odd rows complete the window into an output FIFO.
module psum_maxpool_buffer
   import cnn_pkg::*;
#(
   parameter int DATA_W     = PSUM_W,
   parameter int IMG_W      = IMG_W_DEF,
   parameter int IMG_H      = IMG_H_DEF,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              clear,
   input  logic [DATA_W-1:0] psum_in,
   input  logic              psum_valid,
   output logic              psum_ready,
   output logic [DATA_W-1:0] pool_out,
   output logic              pool_valid,
   input  logic              pool_ready,
   output logic              pool_last,
   output logic              frame_done
);

   // Column counter is one bit wider than the line-buffer address so that
   // col[LB_AW:1] is the pair index and col[0] the position within the pair.
   localparam int LB_AW = ((IMG_W / 2) > 1) ? $clog2(IMG_W / 2) : 1;
   localparam int COL_W = LB_AW + 1;
   localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   logic [COL_W-1:0]  col_r;
   logic [ROW_W-1:0]  row_r;
   logic [DATA_W-1:0] hold_r;
   logic [DATA_W-1:0] linebuf_r [0:(1 << LB_AW)-1];
   logic              run_r;
   logic              frame_done_r;

   logic              accept_s;
   logic              col_last_s;
   logic              row_last_s;
   logic [DATA_W-1:0] hmax_s;
   logic [DATA_W-1:0] vmax_s;
   logic              push_s;
   logic              pop_s;
   logic [DATA_W:0]   push_data_s;
   logic [DATA_W:0]   head_s;
   logic              full_s;
   logic              empty_s;
   logic [CNT_W-1:0]  count_s;

   // Input handshake and window arithmetic. run_r keeps ready low while in reset.
   always_comb begin
      psum_ready  = run_r & en & ~clear & (count_s != CNT_W'(FIFO_DEPTH));
      accept_s    = psum_valid & psum_ready;
      col_last_s  = (col_r == COL_W'(IMG_W - 1));
      row_last_s  = (row_r == ROW_W'(IMG_H - 1));
      hmax_s      = psum_max(hold_r, psum_in);
      vmax_s      = psum_max(linebuf_r[col_r[LB_AW:1]], hmax_s);
      push_s      = accept_s & col_r[0] & row_r[0];
      push_data_s = {row_last_s & col_last_s, vmax_s};
      pop_s       = pool_valid & pool_ready;
   end

   // Raster position of the next sample; only accepted samples advance it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col_r <= {COL_W{1'b0}};
         row_r <= {ROW_W{1'b0}};
      end else if (clear) begin
         col_r <= {COL_W{1'b0}};
         row_r <= {ROW_W{1'b0}};
      end else if (accept_s) begin
         if (col_last_s) begin
            col_r <= {COL_W{1'b0}};
            row_r <= row_last_s ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
         end else begin
            col_r <= col_r + COL_W'(1);
         end
      end
   end

   // Left half of each horizontal pair waits here for its partner.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_r <= {DATA_W{1'b0}};
      end else if (clear) begin
         hold_r <= {DATA_W{1'b0}};
      end else if (accept_s & ~col_r[0]) begin
         hold_r <= psum_in;
      end
   end

   // Even-row pair maxima; always written before the odd row reads them.
   always_ff @(posedge clk) begin
      if (accept_s & col_r[0] & ~row_r[0]) begin
         linebuf_r[col_r[LB_AW:1]] <= hmax_s;
      end
   end

   // Ready gate: released one cycle after reset deasserts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_r <= 1'b0;
      end else begin
         run_r <= 1'b1;
      end
   end

   // One-cycle pulse after the final pooled value of a frame is taken.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_done_r <= 1'b0;
      end else if (clear) begin
         frame_done_r <= 1'b0;
      end else begin
         frame_done_r <= pop_s & head_s[DATA_W];
      end
   end

   sync_fwft_fifo #(
      .W     (DATA_W + 1),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .push      (push_s & ~full_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .head_data (head_s),
      .full      (full_s),
      .empty     (empty_s),
      .count     (count_s)
   );

   assign pool_out   = head_s[DATA_W-1:0];
   assign pool_last  = head_s[DATA_W];
   assign pool_valid = ~empty_s;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_psum_maxpool_buffer.sv
// Self-checking bench for psum_maxpool_buffer on a 4x4 map. A reference
// model stores each frame in a 2D array and pools completed 2x2 windows.
module tb_psum_maxpool_buffer;

   localparam int DW = 8;
   localparam int IW = 4;
   localparam int IH = 4;
   localparam int FD = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic          clear;
   logic [DW-1:0] psum_in;
   logic          psum_valid;
   logic          psum_ready;
   logic [DW-1:0] pool_out;
   logic          pool_valid;
   logic          pool_ready;
   logic          pool_last;
   logic          frame_done;

   always #5 clk = ~clk;

   psum_maxpool_buffer #(
      .DATA_W     (DW),
      .IMG_W      (IW),
      .IMG_H      (IH),
      .FIFO_DEPTH (FD)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .clear      (clear),
      .psum_in    (psum_in),
      .psum_valid (psum_valid),
      .psum_ready (psum_ready),
      .pool_out   (pool_out),
      .pool_valid (pool_valid),
      .pool_ready (pool_ready),
      .pool_last  (pool_last),
      .frame_done (frame_done)
   );

   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } ent_t;

   int   checks = 0;
   int   errors = 0;
   ent_t q[$];
   int   got[$];
   int   img [IH][IW];
   int   mc;
   int   mr;
   bit   exp_fd;
   bit   chk_en;
   int   fd_cnt;
   bit   exp_ready;
   bit   popped_last;
   ent_t e;
   logic [DW-1:0] frame1 [16] = '{8'd1, 8'd5, 8'd2, 8'd3, 8'd4, 8'd0, 8'd9, 8'd7,
                                  8'd10, 8'd10, 8'd0, 8'd0, 8'd10, 8'd11, 8'd0, 8'd255};
   int   ref_out [4] = '{5, 9, 11, 255};

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
      end
   endtask

   function automatic int max4(input int a, input int b, input int c, input int d);
      int m;
      m = a;
      if (b > m) m = b;
      if (c > m) m = c;
      if (d > m) m = d;
      return m;
   endfunction

   task automatic model_reset();
      q.delete();
      mc     = 0;
      mr     = 0;
      exp_fd = 1'b0;
   endtask

   // Reference model and output checker, sampled on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         popped_last = 1'b0;
         check_eq("frame_done", 32'(frame_done), 32'(exp_fd));
         if (frame_done) fd_cnt++;
         exp_ready = en && !clear && (q.size() != FD);
         check_eq("psum_ready", 32'(psum_ready), 32'(exp_ready));
         check_eq("pool_valid", 32'(pool_valid), 32'(q.size() != 0));
         if (pool_valid && pool_ready && q.size() != 0) begin
            check_eq("pool_out", 32'(pool_out), 32'(q[0].d));
            check_eq("pool_last", 32'(pool_last), 32'(q[0].l));
            got.push_back(int'(pool_out));
            popped_last = q[0].l;
            void'(q.pop_front());
         end
         if (clear) begin
            model_reset();
         end else begin
            if (psum_valid && exp_ready) begin
               img[mr][mc] = int'(psum_in);
               if ((mr % 2 == 1) && (mc % 2 == 1)) begin
                  e.d = 8'(max4(img[mr-1][mc-1], img[mr-1][mc], img[mr][mc-1], img[mr][mc]));
                  e.l = (mr == IH - 1) && (mc == IW - 1);
                  q.push_back(e);
               end
               mc++;
               if (mc == IW) begin
                  mc = 0;
                  mr++;
                  if (mr == IH) mr = 0;
               end
            end
            exp_fd = popped_last;
         end
      end
   end

   task automatic send_sample(input logic [DW-1:0] v);
      bit ok;
      ok         = 1'b0;
      psum_valid = 1'b1;
      psum_in    = v;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (psum_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("accept_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input int gap_at, input bit lat_chk);
      for (int i = 0; i < 16; i++) begin
         if (i == gap_at) begin
            en         = 1'b0;
            psum_valid = 1'b1;
            psum_in    = frame1[i];
            for (int g = 0; g < 3; g++) begin
               @(negedge clk);
               check_eq("en_gap_ready", 32'(psum_ready), 32'd0);
            end
            @(posedge clk);
            #1;
            en = 1'b1;
         end
         send_sample(frame1[i]);
         if (lat_chk && i == 7) begin
            check_eq("lat_valid", 32'(pool_valid), 32'd1);
            check_eq("lat_out", 32'(pool_out), 32'd9);
         end
      end
      psum_valid = 1'b0;
   endtask

   task automatic wait_drain();
      bit ok;
      ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (q.size() == 0 && !pool_valid) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) check_eq("drain_timeout", 32'd0, 32'd1);
      repeat (2) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   task automatic check_frames(input int nf);
      check_eq("n_out", 32'(got.size()), 32'(nf * 4));
      for (int i = 0; i < got.size(); i++) begin
         check_eq("out_val", 32'(got[i]), 32'(ref_out[i % 4]));
      end
      check_eq("fd_count", 32'(fd_cnt), 32'(nf));
   endtask

   task automatic start_scenario(input logic pr);
      got.delete();
      fd_cnt     = 0;
      pool_ready = pr;
   endtask

   initial begin
      bit bp_ok;
      rst_n      = 1'b0;
      en         = 1'b1;
      clear      = 1'b0;
      psum_valid = 1'b0;
      psum_in    = '0;
      pool_ready = 1'b1;
      chk_en     = 1'b0;
      fd_cnt     = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_psum_ready", 32'(psum_ready), 32'd0);
      check_eq("rst_pool_valid", 32'(pool_valid), 32'd0);
      check_eq("rst_pool_out", 32'(pool_out), 32'd0);
      check_eq("rst_pool_last", 32'(pool_last), 32'd0);
      check_eq("rst_frame_done", 32'(frame_done), 32'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;

      // Basic frame with first-result latency check
      start_scenario(1'b1);
      send_frame(-1, 1'b1);
      wait_drain();
      check_frames(1);

      // Backpressure across two back-to-back frames
      start_scenario(1'b0);
      fork
         begin
            send_frame(-1, 1'b0);
            send_frame(-1, 1'b0);
         end
         begin
            bp_ok = 1'b0;
            for (int k = 0; k < 300; k++) begin
               @(negedge clk);
               if (q.size() == FD) begin
                  bp_ok = 1'b1;
                  break;
               end
            end
            if (!bp_ok) check_eq("bp_fill_timeout", 32'd0, 32'd1);
            repeat (4) @(negedge clk);
            check_eq("bp_ready_low", 32'(psum_ready), 32'd0);
            check_eq("bp_valid_high", 32'(pool_valid), 32'd1);
            @(posedge clk);
            #1;
            pool_ready = 1'b1;
         end
      join
      wait_drain();
      check_frames(2);

      // Enable dropped for three cycles in the middle of row 2
      start_scenario(1'b1);
      send_frame(9, 1'b0);
      wait_drain();
      check_frames(1);

      // Clear after six samples discards the partial frame and its queued result
      start_scenario(1'b0);
      for (int i = 0; i < 6; i++) send_sample(frame1[i]);
      psum_valid = 1'b0;
      clear      = 1'b1;
      @(posedge clk);
      #1;
      clear = 1'b0;
      check_eq("clr_pool_valid", 32'(pool_valid), 32'd0);
      pool_ready = 1'b1;
      send_frame(-1, 1'b0);
      wait_drain();
      check_frames(1);

      // Asynchronous reset with a full FIFO
      start_scenario(1'b0);
      send_frame(-1, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      check_eq("pre_rst_valid", 32'(pool_valid), 32'd1);
      @(negedge clk);
      #2;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      check_eq("arst_pool_valid", 32'(pool_valid), 32'd0);
      check_eq("arst_psum_ready", 32'(psum_ready), 32'd0);
      check_eq("arst_pool_out", 32'(pool_out), 32'd0);
      check_eq("arst_pool_last", 32'(pool_last), 32'd0);
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_en = 1'b1;
      start_scenario(1'b1);
      send_frame(-1, 1'b1);
      wait_drain();
      check_frames(1);

      // Randomised traffic against the reference model
      for (int c = 0; c < 2000; c++) begin
         psum_valid = ($urandom_range(0, 3) != 0);
         psum_in    = 8'($urandom);
         en         = ($urandom_range(0, 9) != 0);
         pool_ready = ($urandom_range(0, 2) != 0);
         clear      = ($urandom_range(0, 149) == 0);
         @(posedge clk);
         #1;
      end
      psum_valid = 1'b0;
      clear      = 1'b0;
      en         = 1'b1;
      pool_ready = 1'b1;
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
